// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner with whole-scan debounce.
// Emits a hex key code, a one-cycle press strobe and a held level.
`timescale 1ns/1ps
module keypad_scanner #(
   parameter int SCAN_DIV       = 100000,
   parameter int DEBOUNCE_SCANS = 4
) (
   input  logic       clk,
   input  logic       clr,
   input  logic [3:0] row,
   output logic [3:0] col,
   output logic [3:0] key_code,
   output logic       key_valid,
   output logic       key_held
);

   localparam int CW = $clog2(SCAN_DIV);
   localparam logic [CW-1:0] LAST = CW'(SCAN_DIV - 1);
   localparam logic [3:0] DBN = 4'(DEBOUNCE_SCANS);

   typedef enum logic [1:0] {
      R_NONE, R_SINGLE, R_MULTI
   } res_e;

   typedef enum logic [1:0] {
      IDLE, PRESS_WAIT, HELD, RELEASE_WAIT
   } state_e;

   logic [3:0]    row_s1_q, row_s2_q;
   logic [CW-1:0] slot_q;
   logic [1:0]    idx_q;
   res_e          acc_kind_q;
   logic [3:0]    acc_code_q;

   state_e        state_q, state_d;
   logic [3:0]    cnt_q, cnt_d;
   logic [3:0]    cand_q, cand_d;
   logic [3:0]    code_q, code_d;
   logic          valid_q, valid_d;

   logic [3:0]    rows_low;
   logic [1:0]    row_idx;
   res_e          col_kind;
   res_e          scan_kind;
   logic [3:0]    scan_code;
   logic          sample;
   logic          scan_end;

   assign rows_low  = ~row_s2_q;
   assign sample    = (slot_q == LAST);
   assign scan_end  = sample && (idx_q == 2'd3);
   assign col       = ~(4'b0001 << idx_q);
   assign key_code  = code_q;
   assign key_valid = valid_q;
   assign key_held  = (state_q == HELD) || (state_q == RELEASE_WAIT);

   // Two-flop synchroniser for the asynchronous row inputs
   always_ff @(posedge clk) begin
      if (!clr) begin
         row_s1_q <= 4'b1111;
         row_s2_q <= 4'b1111;
      end else begin
         row_s1_q <= row;
         row_s2_q <= row_s1_q;
      end
   end

   // Classify the current column sample and merge it into the scan result
   always_comb begin
      row_idx = 2'd0;
      for (int r = 3; r >= 0; r--) begin
         if (rows_low[r]) row_idx = 2'(r);
      end
      if (rows_low == 4'b0000)   col_kind = R_NONE;
      else if ($onehot(rows_low)) col_kind = R_SINGLE;
      else                        col_kind = R_MULTI;
      scan_kind = acc_kind_q;
      scan_code = acc_code_q;
      if (col_kind != R_NONE) begin
         if (acc_kind_q == R_NONE) begin
            scan_kind = col_kind;
            scan_code = {row_idx, idx_q};
         end else begin
            scan_kind = R_MULTI;
         end
      end
   end

   // Column slot timing and per-scan accumulation
   always_ff @(posedge clk) begin
      if (!clr) begin
         slot_q     <= '0;
         idx_q      <= 2'd0;
         acc_kind_q <= R_NONE;
         acc_code_q <= 4'd0;
      end else if (sample) begin
         slot_q <= '0;
         idx_q  <= idx_q + 2'd1;
         if (scan_end) begin
            acc_kind_q <= R_NONE;
            acc_code_q <= 4'd0;
         end else begin
            acc_kind_q <= scan_kind;
            acc_code_q <= scan_code;
         end
      end else begin
         slot_q <= slot_q + CW'(1);
      end
   end

   // Debounce FSM state register
   always_ff @(posedge clk) begin
      if (!clr) begin
         state_q <= IDLE;
         cnt_q   <= 4'd0;
         cand_q  <= 4'd0;
         code_q  <= 4'd0;
         valid_q <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         cand_q  <= cand_d;
         code_q  <= code_d;
         valid_q <= valid_d;
      end
   end

   // Debounce FSM next state, evaluated only at scan end
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      cand_d  = cand_q;
      code_d  = code_q;
      valid_d = 1'b0;
      if (scan_end) begin
         unique case (state_q)
            IDLE: begin
               if (scan_kind == R_SINGLE) begin
                  cand_d  = scan_code;
                  cnt_d   = 4'd1;
                  state_d = PRESS_WAIT;
               end
            end
            PRESS_WAIT: begin
               if (scan_kind == R_SINGLE) begin
                  if (scan_code == cand_q) begin
                     if (cnt_q + 4'd1 == DBN) begin
                        code_d  = cand_q;
                        valid_d = 1'b1;
                        cnt_d   = 4'd0;
                        state_d = HELD;
                     end else begin
                        cnt_d = cnt_q + 4'd1;
                     end
                  end else begin
                     cand_d = scan_code;
                     cnt_d  = 4'd1;
                  end
               end else begin
                  cnt_d   = 4'd0;
                  state_d = IDLE;
               end
            end
            HELD: begin
               if (scan_kind == R_NONE) begin
                  cnt_d   = 4'd1;
                  state_d = RELEASE_WAIT;
               end
            end
            RELEASE_WAIT: begin
               if (scan_kind == R_NONE) begin
                  if (cnt_q + 4'd1 == DBN) begin
                     cnt_d   = 4'd0;
                     state_d = IDLE;
                  end else begin
                     cnt_d = cnt_q + 4'd1;
                  end
               end else begin
                  cnt_d   = 4'd0;
                  state_d = HELD;
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner.
// SCAN_DIV=4, DEBOUNCE_SCANS=3: a scan is 16 cycles.
`timescale 1ns/1ps
module tb_keypad_scanner;

   logic        clk;
   logic        clr;
   logic [3:0]  row;
   logic [3:0]  col;
   logic [3:0]  key_code;
   logic        key_valid;
   logic        key_held;

   logic [15:0] keys;
   int          ntests;
   int          nfail;
   int          cyc;
   int          npulse;
   int          p0;
   logic        prev_v;
   logic        consec;

   keypad_scanner #(
      .SCAN_DIV      (4),
      .DEBOUNCE_SCANS(3)
   ) dut (
      .clk      (clk),
      .clr      (clr),
      .row      (row),
      .col      (col),
      .key_code (key_code),
      .key_valid(key_valid),
      .key_held (key_held)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: time limit reached");
      $fatal(1, "watchdog");
   end

   // Keypad model: row r pulled low when column c driven low and key (r,c) down
   always_comb begin
      row = 4'hF;
      for (int r = 0; r < 4; r++) begin
         for (int c = 0; c < 4; c++) begin
            if (keys[r*4+c] && !col[c]) row[r] = 1'b0;
         end
      end
   end

   // Count press strobes and flag back-to-back strobes
   initial begin
      npulse = 0;
      prev_v = 1'b0;
      consec = 1'b0;
   end
   always @(posedge clk) begin
      if (key_valid) npulse <= npulse + 1;
      if (key_valid && prev_v) consec <= 1'b1;
      prev_v <= key_valid;
   end

   task automatic tick();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic go(input int t);
      while (cyc < t) tick();
   endtask

   task automatic chk(input string tag, input logic [15:0] obs,
                      input logic [15:0] exp);
      ntests++;
      assert (obs === exp) else begin
         nfail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic do_reset(input int n);
      clr = 1'b0;
      repeat (n) tick();
      clr = 1'b1;
      cyc = 0;
   endtask

   initial begin
      ntests = 0;
      nfail  = 0;
      cyc    = 0;
      clr    = 1'b0;
      keys   = 16'hFFFF;

      // Reset with an arbitrary key pattern
      clr = 1'b0;
      repeat (3) tick();
      chk("rst_col", 16'(col), 16'hE);
      chk("rst_code", 16'(key_code), 16'h0);
      chk("rst_valid", 16'(key_valid), 16'h0);
      chk("rst_held", 16'(key_held), 16'h0);
      keys = 16'h0;
      clr  = 1'b1;
      cyc  = 0;
      chk("col@0", 16'(col), 16'hE);
      go(3);
      chk("col@3", 16'(col), 16'hE);
      go(4);
      chk("col@4", 16'(col), 16'hD);
      go(8);
      chk("col@8", 16'(col), 16'hB);
      go(12);
      chk("col@12", 16'(col), 16'h7);
      go(16);
      chk("col@16", 16'(col), 16'hE);

      // Clean press of (2,1) -> code 9
      do_reset(1);
      keys = 16'h0200;
      p0   = npulse;
      go(47);
      chk("press_v@47", 16'(key_valid), 16'h0);
      chk("press_h@47", 16'(key_held), 16'h0);
      tick();
      chk("press_v@48", 16'(key_valid), 16'h1);
      chk("press_code", 16'(key_code), 16'h9);
      chk("press_h@48", 16'(key_held), 16'h1);
      tick();
      chk("press_v@49", 16'(key_valid), 16'h0);
      go(90);
      chk("press_h@90", 16'(key_held), 16'h1);
      chk("press_cnt", 16'(npulse - p0), 16'h1);

      // Release debounce: 2 empty scans, 1 pressed, 3 empty
      go(96);
      keys = 16'h0;
      go(120);
      chk("rel_h@120", 16'(key_held), 16'h1);
      go(128);
      keys = 16'h0200;
      go(144);
      chk("rel_h@144", 16'(key_held), 16'h1);
      keys = 16'h0;
      go(191);
      chk("rel_h@191", 16'(key_held), 16'h1);
      tick();
      chk("rel_h@192", 16'(key_held), 16'h0);
      chk("rel_code", 16'(key_code), 16'h9);
      chk("rel_cnt", 16'(npulse - p0), 16'h1);

      // Bounce reject on (0,3)
      do_reset(1);
      keys = 16'h0008;
      p0   = npulse;
      go(16);
      keys = 16'h0;
      go(32);
      keys = 16'h0008;
      go(50);
      chk("bnc_h@50", 16'(key_held), 16'h0);
      go(64);
      keys = 16'h0;
      go(112);
      chk("bnc_h@112", 16'(key_held), 16'h0);
      chk("bnc_cnt", 16'(npulse - p0), 16'h0);

      // Multi-key (1,1)+(3,2), then only (1,1) -> code 5
      do_reset(1);
      keys = 16'h4020;
      p0   = npulse;
      go(80);
      chk("multi_cnt", 16'(npulse - p0), 16'h0);
      chk("multi_h", 16'(key_held), 16'h0);
      keys = 16'h0020;
      go(127);
      chk("multi_v@127", 16'(key_valid), 16'h0);
      tick();
      chk("multi_v@128", 16'(key_valid), 16'h1);
      chk("multi_code", 16'(key_code), 16'h5);
      go(140);
      chk("multi_h@140", 16'(key_held), 16'h1);
      chk("multi_cnt2", 16'(npulse - p0), 16'h1);

      // Reset mid-hold with key still down
      clr = 1'b0;
      tick();
      chk("mrst_col", 16'(col), 16'hE);
      chk("mrst_code", 16'(key_code), 16'h0);
      chk("mrst_valid", 16'(key_valid), 16'h0);
      chk("mrst_held", 16'(key_held), 16'h0);
      clr = 1'b1;
      cyc = 0;
      p0  = npulse;
      go(47);
      chk("mrst_v@47", 16'(key_valid), 16'h0);
      tick();
      chk("mrst_v@48", 16'(key_valid), 16'h1);
      chk("mrst_code2", 16'(key_code), 16'h5);
      tick();
      chk("mrst_cnt", 16'(npulse - p0), 16'h1);

      chk("no_consec", 16'(consec), 16'h0);

      $display("[TB] %0d tests run, %0d failed", ntests, nfail);
      $finish;
   end

endmodule
